// File: rtl/synaptic_current_if.sv
// Synaptic-current bus: groups the step/spike/parameter inputs and the current/status outputs
// of one synapse.
//   master : drives apply, pre_spike, delay, weight, decay, i_bias, clear;
//            observes i_syn, i_out, spike_arrived, arrived_count, saturated
//   slave  : the synapse itself (directions reversed)
interface synaptic_current_if #(
    parameter int unsigned N   = 18,
    parameter int unsigned D_W = 4
);
    logic                  apply;
    logic                  pre_spike;
    logic [D_W-1:0]        delay;
    logic signed [N-1:0]   weight;
    logic [N-1:0]          decay;
    logic signed [N-1:0]   i_bias;
    logic                  clear;
    logic signed [N-1:0]   i_syn;
    logic signed [N-1:0]   i_out;
    logic                  spike_arrived;
    logic [15:0]           arrived_count;
    logic                  saturated;

    modport master (
        output apply, pre_spike, delay, weight, decay, i_bias, clear,
        input  i_syn, i_out, spike_arrived, arrived_count, saturated
    );

    modport slave (
        input  apply, pre_spike, delay, weight, decay, i_bias, clear,
        output i_syn, i_out, spike_arrived, arrived_count, saturated
    );
endinterface

// File: rtl/synaptic_current.sv
// Synaptic current: delays presynaptic spikes by a programmable number of steps through a 1-bit
// ring buffer, then turns each arrival into a jump of an exponentially decaying current.
//   clk, rst         : clock, asynchronous active-high reset
//   bus.apply        : step strobe (one step per cycle sampled high)
//   bus.pre_spike    : presynaptic spike, sampled with apply
//   bus.delay        : axonal delay in steps, sampled with pre_spike
//   bus.weight       : signed Q jump per arrival
//   bus.decay        : unsigned Q per-step decay factor
//   bus.i_bias       : signed Q constant added to the output current
//   bus.clear        : synchronous clear of all state
//   bus.i_syn        : synaptic state current
//   bus.i_out        : sat(i_syn + i_bias)
//   bus.spike_arrived: a delayed spike landed in the last step
//   bus.arrived_count: saturating arrival counter
//   bus.saturated    : sticky clamp flag
module synaptic_current #(
    parameter int unsigned N         = 18,
    parameter int unsigned Q         = 10,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned D_W       = 4
) (
    input logic               clk,
    input logic               rst,
    synaptic_current_if.slave bus
);
    // Wide enough to hold the full decayed product plus a jump without wrapping,
    // so clamping stays correct even for out-of-range decay factors.
    localparam int unsigned SW = 2 * N + 2;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW - N + 1){1'b1}}, {(N - 1){1'b0}}};

    function automatic logic in_range(input logic signed [SW-1:0] v);
        return (v <= SAT_MAX) && (v >= SAT_MIN);
    endfunction

    function automatic logic [N-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[N-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[N-1:0];
        end
        return v[N-1:0];
    endfunction

    logic [MAX_DELAY-1:0]  slot_q, slot_d;
    logic [D_W-1:0]        ptr_q, tgt;
    logic signed [N-1:0]   i_syn_q, i_syn_d;
    logic signed [N-1:0]   i_out_q, i_out_d;
    logic                  arrived_q, arrive;
    logic [15:0]           count_q, count_d;
    logic                  sat_q, sat_d;
    logic signed [2*N:0]   prod;
    logic signed [SW-1:0]  dec_w, jump_w, nxt_w, out_w;

    always_comb begin
        arrive = slot_q[ptr_q] | (bus.pre_spike & (bus.delay == '0));

        // Index arithmetic is D_W wide, so the target wraps around the ring for free.
        tgt = ptr_q + bus.delay;
        slot_d = slot_q;
        slot_d[ptr_q] = 1'b0;
        if (bus.pre_spike && (bus.delay != '0)) begin
            slot_d[tgt] = 1'b1;
        end

        prod   = $signed({{(N + 1){i_syn_q[N-1]}}, i_syn_q})
               * $signed({{N{1'b0}}, 1'b0, bus.decay});
        dec_w  = $signed({prod[2*N], prod}) >>> Q;
        jump_w = arrive ? $signed({{(SW - N){bus.weight[N-1]}}, bus.weight}) : '0;
        nxt_w  = dec_w + jump_w;
        i_syn_d = clamp(nxt_w);

        out_w  = $signed({{(SW - N){i_syn_d[N-1]}}, i_syn_d})
               + $signed({{(SW - N){bus.i_bias[N-1]}}, bus.i_bias});
        i_out_d = clamp(out_w);

        count_d = (arrive && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
        sat_d   = sat_q | ~in_range(nxt_w) | ~in_range(out_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= '0;
            ptr_q     <= '0;
            i_syn_q   <= '0;
            i_out_q   <= '0;
            arrived_q <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else if (bus.clear) begin
            slot_q    <= '0;
            ptr_q     <= '0;
            i_syn_q   <= '0;
            i_out_q   <= '0;
            arrived_q <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else if (bus.apply) begin
            slot_q    <= slot_d;
            ptr_q     <= ptr_q + D_W'(1);
            i_syn_q   <= i_syn_d;
            i_out_q   <= i_out_d;
            arrived_q <= arrive;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.i_syn         = i_syn_q;
    assign bus.i_out         = i_out_q;
    assign bus.spike_arrived = arrived_q;
    assign bus.arrived_count = count_q;
    assign bus.saturated     = sat_q;
endmodule

// File: tb/tb_synaptic_current.sv
module tb_synaptic_current;
    typedef struct {
        int    pre;
        int    dly;
        int    w;
        int    dec;
        int    bias;
        int    clr;
        int    app;
        int    e_syn;
        int    e_out;
        int    e_arr;
        int    e_cnt;
        int    e_sat;
        string name;
    } vec_t;

    typedef struct {
        int    syn;
        int    out;
        int    arr;
        int    cnt;
        int    sat;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    synaptic_current_if #(.N(18), .D_W(4)) bus ();

    synaptic_current #(
        .N(18),
        .Q(10),
        .MAX_DELAY(16),
        .D_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int pre, int dly, int w, int dec, int bias, int clr, int app,
                                int e_syn, int e_out, int e_arr, int e_cnt, int e_sat,
                                string name);
        vec_t v;
        v.pre = pre; v.dly = dly; v.w = w; v.dec = dec; v.bias = bias; v.clr = clr; v.app = app;
        v.e_syn = e_syn; v.e_out = e_out; v.e_arr = e_arr; v.e_cnt = e_cnt; v.e_sat = e_sat;
        v.name = name;
        return v;
    endfunction

    task automatic check(input exp_t e);
        int a_syn, a_out, a_arr, a_cnt, a_sat;
        a_syn = int'($signed(bus.i_syn));
        a_out = int'($signed(bus.i_out));
        a_arr = int'(bus.spike_arrived);
        a_cnt = int'(bus.arrived_count);
        a_sat = int'(bus.saturated);
        n_vec++;
        if (a_syn != e.syn || a_out != e.out || a_arr != e.arr || a_cnt != e.cnt ||
            a_sat != e.sat) begin
            n_bad++;
            $display("FAIL %s: got syn=%0d out=%0d arr=%0d cnt=%0d sat=%0d, want syn=%0d out=%0d arr=%0d cnt=%0d sat=%0d",
                     e.name, a_syn, a_out, a_arr, a_cnt, a_sat,
                     e.syn, e.out, e.arr, e.cnt, e.sat);
        end
    endtask

    // Drive one vector, record its expectation, then compare after the edge.
    task automatic apply_vec(input vec_t v);
        exp_t e;
        bus.pre_spike = v.pre[0];
        bus.delay     = 4'(v.dly);
        bus.weight    = 18'(v.w);
        bus.decay     = 18'(v.dec);
        bus.i_bias    = 18'(v.bias);
        bus.clear     = v.clr[0];
        bus.apply     = v.app[0];
        e.syn = v.e_syn; e.out = v.e_out; e.arr = v.e_arr; e.cnt = v.e_cnt; e.sat = v.e_sat;
        e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue, want one entry");
        end else begin
            check(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        bus.apply = 1'b0; bus.pre_spike = 1'b0; bus.delay = '0; bus.weight = '0;
        bus.decay = '0; bus.i_bias = '0; bus.clear = 1'b0;

        // Table: pre dly w dec bias clr app | syn out arr cnt sat
        // Exponential decay from one spike, plus apply=0 hold
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t1_clear"));
        vecs.push_back(mk(1, 0, 1024, 512, 0, 0, 1, 1024, 1024, 1, 1, 0, "t1_s0"));
        vecs.push_back(mk(1, 0, 1024, 512, 0, 0, 0, 1024, 1024, 1, 1, 0, "t1_hold"));
        vecs.push_back(mk(0, 0, 1024, 512, 0, 0, 1, 512, 512, 0, 1, 0, "t1_s1"));
        vecs.push_back(mk(0, 0, 1024, 512, 0, 0, 1, 256, 256, 0, 1, 0, "t1_s2"));
        vecs.push_back(mk(0, 0, 1024, 512, 0, 0, 1, 128, 128, 0, 1, 0, "t1_s3"));
        // Delay of 3 steps with apply gaps
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t2_clear"));
        vecs.push_back(mk(1, 3, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t2_s0"));
        vecs.push_back(mk(0, 3, 1024, 1024, 0, 0, 0, 0, 0, 0, 0, 0, "t2_gap0"));
        vecs.push_back(mk(0, 3, 1024, 1024, 0, 0, 0, 0, 0, 0, 0, 0, "t2_gap1"));
        vecs.push_back(mk(0, 3, 1024, 1024, 0, 0, 0, 0, 0, 0, 0, 0, "t2_gap2"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t2_s1"));
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 0, 0, 0, 0, 0, 0, 0, "t2_gap_spike"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 0, 0, 0, 0, 0, 0, "t2_gap3"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t2_s2"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 1024, 1024, 1, 1, 0, "t2_s3"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 1024, 1024, 0, 1, 0, "t2_s4"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 1024, 1024, 0, 1, 0, "t2_s5"));
        // Positive and negative saturation of i_syn
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t3_clear"));
        vecs.push_back(mk(1, 0, 100000, 1024, 0, 0, 1, 100000, 100000, 1, 1, 0, "t3_s0"));
        vecs.push_back(mk(1, 0, 100000, 1024, 0, 0, 1, 131071, 131071, 1, 2, 1, "t3_s1"));
        vecs.push_back(mk(0, 0, 100000, 1024, 0, 0, 1, 131071, 131071, 0, 2, 1, "t3_s2"));
        vecs.push_back(mk(1, 0, -100000, 1024, 0, 0, 1, 31071, 31071, 1, 3, 1, "t3_n0"));
        vecs.push_back(mk(1, 0, -100000, 1024, 0, 0, 1, -68929, -68929, 1, 4, 1, "t3_n1"));
        vecs.push_back(mk(1, 0, -100000, 1024, 0, 0, 1, -131072, -131072, 1, 5, 1, "t3_n2"));
        vecs.push_back(mk(1, 0, -100000, 1024, 0, 0, 1, -131072, -131072, 1, 6, 1, "t3_n3"));
        // Bias and output saturation
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t6_clear"));
        vecs.push_back(mk(1, 0, 1024, 1024, -2048, 0, 1, 1024, -1024, 1, 1, 0, "t6_neg_bias"));
        vecs.push_back(mk(0, 0, 1024, 1024, 131071, 0, 1, 1024, 131071, 0, 1, 1, "t6_out_sat"));
        // A pending spike is discarded by clear (clear beats apply on the same edge)
        vecs.push_back(mk(1, 2, 1024, 1024, 0, 0, 1, 1024, 1024, 0, 1, 1, "t5_sched"));
        vecs.push_back(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t5_clear_apply"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t5_after0"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t5_after1"));
        vecs.push_back(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0, "t5_after2"));

        // Reset state
        #2;
        z.syn = 0; z.out = 0; z.arr = 0; z.cnt = 0; z.sat = 0; z.name = "reset";
        check(z);
        #10;
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Delay 15 on every step across the ring wrap, then a shorter delay that coalesces
        apply_vec(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, "t4_clear"));
        for (int k = 0; k < 58; k++) begin
            int arr, cnt, pre, dly;
            pre = (k <= 40) ? 1 : 0;
            dly = (k == 40) ? 2 : 15;
            arr = (k >= 15 && k <= 54) ? 1 : 0;
            cnt = (k < 15) ? 0 : ((k <= 54) ? k - 14 : 40);
            apply_vec(mk(pre, dly, 1, 0, 0, 0, 1, arr, arr, arr, cnt, 0,
                         $sformatf("t4_step%0d", k)));
        end

        // Asynchronous reset in the middle of a cycle with a spike pending
        apply_vec(mk(1, 0, 1024, 1024, 0, 1, 1, 0, 0, 0, 0, 0, "t5r_clear"));
        apply_vec(mk(1, 0, 1024, 1024, 0, 0, 1, 1024, 1024, 1, 1, 0, "t5r_s0"));
        apply_vec(mk(1, 3, 1024, 1024, 0, 0, 1, 1024, 1024, 0, 1, 0, "t5r_sched"));
        #3;
        rst = 1'b1;
        #1;
        z.name = "async_reset";
        check(z);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_vec(mk(0, 0, 1024, 1024, 0, 0, 1, 0, 0, 0, 0, 0,
                         $sformatf("t5r_after%0d", k)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
